// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bus of the PS/2 scan-code decoder.
// The decoder takes the slave modport; the byte source and event consumer take master.
interface ps2_scancode_decoder_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    i_data;
    logic          i_data_valid;
    logic [7:0]    o_evt_code;
    logic          o_evt_ext;
    logic          o_evt_break;
    logic          o_evt_valid;
    logic          i_evt_ready;
    logic [LW-1:0] o_level;
    logic          o_overflow;
    logic          i_ovf_clr;
    logic          o_seq_err;

    modport master (
        output i_data, i_data_valid, i_evt_ready, i_ovf_clr,
        input  o_evt_code, o_evt_ext, o_evt_break, o_evt_valid, o_level, o_overflow, o_seq_err
    );

    modport slave (
        input  i_data, i_data_valid, i_evt_ready, i_ovf_clr,
        output o_evt_code, o_evt_ext, o_evt_break, o_evt_valid, o_level, o_overflow, o_seq_err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events,
// optionally filters typematic repeats, and queues events in a FWFT FIFO.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 250000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_REPEAT  = 1
) (
    input logic                   i_clk,
    input logic                   i_rst,
    ps2_scancode_decoder_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PFX_E0   = 3'd1;
    localparam logic [2:0] PFX_F0   = 3'd2;
    localparam logic [2:0] PFX_E0F0 = 3'd3;
    localparam logic [2:0] SKIP_E1  = 3'd4;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    logic [2:0]    state_q, state_d;
    logic [2:0]    remain_q, remain_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          seq_err_q;
    logic          seq_err_c;
    logic          emit_c;
    evt_t          evt_c;
    logic [8:0]    held_q;
    logic          held_vld_q;
    logic          push_c;

    evt_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          ovf_q;

    logic       is_ctrl_c;
    logic       is_pfx_c;
    logic       restart_c;
    logic [2:0] eff_state_c;
    logic [7:0] d;

    assign d = bus.i_data;

    // Byte classification; a stray prefix inside a sequence restarts it from IDLE
    always_comb begin
        is_ctrl_c = 1'b0;
        is_pfx_c  = 1'b0;
        case (d)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'hFD, 8'h00, 8'hFF: is_ctrl_c = 1'b1;
            8'hE0, 8'hF0, 8'hE1:                                    is_pfx_c  = 1'b1;
            default: ;
        endcase
        restart_c   = is_pfx_c && (state_q != IDLE) && !((state_q == PFX_E0) && (d == 8'hF0));
        eff_state_c = restart_c ? IDLE : state_q;
    end

    // Next-state, event generation and inter-byte timeout
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        cnt_d     = cnt_q;
        emit_c    = 1'b0;
        evt_c     = '0;
        seq_err_c = 1'b0;
        if (bus.i_data_valid) begin
            cnt_d = '0;
            if (state_q == SKIP_E1) begin
                remain_d = remain_q - 3'd1;
                if (remain_q == 3'd1) begin
                    emit_c  = 1'b1;
                    evt_c   = '{ext: 1'b1, brk: 1'b0, code: 8'hE1};
                    state_d = IDLE;
                end
            end else if (!is_ctrl_c) begin
                seq_err_c = restart_c;
                case (eff_state_c)
                    IDLE: begin
                        if (d == 8'hE0) begin
                            state_d = PFX_E0;
                        end else if (d == 8'hF0) begin
                            state_d = PFX_F0;
                        end else if (d == 8'hE1) begin
                            state_d  = SKIP_E1;
                            remain_d = 3'd7;
                        end else begin
                            emit_c = 1'b1;
                            evt_c  = '{ext: 1'b0, brk: 1'b0, code: d};
                        end
                    end
                    PFX_E0: begin
                        if (d == 8'hF0) begin
                            state_d = PFX_E0F0;
                        end else begin
                            emit_c  = 1'b1;
                            evt_c   = '{ext: 1'b1, brk: 1'b0, code: d};
                            state_d = IDLE;
                        end
                    end
                    PFX_F0: begin
                        emit_c  = 1'b1;
                        evt_c   = '{ext: 1'b0, brk: 1'b1, code: d};
                        state_d = IDLE;
                    end
                    PFX_E0F0: begin
                        emit_c  = 1'b1;
                        evt_c   = '{ext: 1'b1, brk: 1'b1, code: d};
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            cnt_d     = '0;
            state_d   = IDLE;
            seq_err_c = 1'b1;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // A make matching the currently held key is a typematic repeat
    assign push_c = emit_c && !((FILTER_REPEAT != 0) && !evt_c.brk && held_vld_q &&
                                (held_q == {evt_c.ext, evt_c.code}));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            remain_q   <= '0;
            cnt_q      <= '0;
            seq_err_q  <= 1'b0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_c;
            if (push_c) begin
                if (!evt_c.brk) begin
                    held_q     <= {evt_c.ext, evt_c.code};
                    held_vld_q <= 1'b1;
                end else if (held_vld_q && (held_q == {evt_c.ext, evt_c.code})) begin
                    held_vld_q <= 1'b0;
                end
            end
        end
    end

    logic full_c, rd_en_c, wr_en_c, drop_c;

    assign full_c  = (count_q == LW'(FIFO_DEPTH));
    assign rd_en_c = (count_q != '0) && bus.i_evt_ready;
    assign wr_en_c = push_c && (!full_c || rd_en_c);
    assign drop_c  = push_c && full_c && !rd_en_c;

    // Event FIFO; pointers wrap naturally because the depth is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= evt_c;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en_c && !rd_en_c) begin
                count_q <= count_q + LW'(1);
            end else if (!wr_en_c && rd_en_c) begin
                count_q <= count_q - LW'(1);
            end
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (bus.i_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.o_evt_code  = mem_q[rd_ptr_q].code;
    assign bus.o_evt_ext   = mem_q[rd_ptr_q].ext;
    assign bus.o_evt_break = mem_q[rd_ptr_q].brk;
    assign bus.o_evt_valid = (count_q != '0);
    assign bus.o_level     = count_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_seq_err   = seq_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: one instance with the repeat filter
// and one without, both fed the same byte stream.
module tb_ps2_scancode_decoder;
    localparam int unsigned TMO = 16;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    ps2_scancode_decoder_if #(.FIFO_DEPTH(8)) bus_a ();
    ps2_scancode_decoder_if #(.FIFO_DEPTH(8)) bus_b ();

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8), .FILTER_REPEAT(1)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_a)
    );

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8), .FILTER_REPEAT(0)) dut_nf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic ext, input logic brk, input logic [7:0] code);
        return 32'({1'b1, ext, brk, code});
    endfunction

    function automatic logic [31:0] head_a();
        return 32'({bus_a.o_evt_valid, bus_a.o_evt_ext, bus_a.o_evt_break, bus_a.o_evt_code});
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus_a.i_data       = b;
        bus_b.i_data       = b;
        bus_a.i_data_valid = 1'b1;
        bus_b.i_data_valid = 1'b1;
        tick();
        bus_a.i_data_valid = 1'b0;
        bus_b.i_data_valid = 1'b0;
    endtask

    task automatic pop();
        bus_a.i_evt_ready = 1'b1;
        bus_b.i_evt_ready = 1'b1;
        tick();
        bus_a.i_evt_ready = 1'b0;
        bus_b.i_evt_ready = 1'b0;
    endtask

    task automatic drain();
        bus_a.i_evt_ready = 1'b1;
        bus_b.i_evt_ready = 1'b1;
        repeat (10) tick();
        bus_a.i_evt_ready = 1'b0;
        bus_b.i_evt_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        logic [7:0] seq_e1 [8];
        checks = 0;
        errors = 0;
        seq_e1 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        bus_a.i_data = '0; bus_a.i_data_valid = 1'b0; bus_a.i_evt_ready = 1'b0; bus_a.i_ovf_clr = 1'b0;
        bus_b.i_data = '0; bus_b.i_data_valid = 1'b0; bus_b.i_evt_ready = 1'b0; bus_b.i_ovf_clr = 1'b0;
        i_rst = 1'b1;
        repeat (3) tick();
        check("rst_head", head_a(), 32'h0);
        check("rst_level", 32'(bus_a.o_level), 32'd0);
        check("rst_ovf", 32'(bus_a.o_overflow), 32'd0);
        check("rst_seqerr", 32'(bus_a.o_seq_err), 32'd0);
        i_rst = 1'b0;
        tick();

        // plain make then break
        send(8'h1D);
        check("make_latency", head_a(), ev(1'b0, 1'b0, 8'h1D));
        send(8'hF0);
        send(8'h1D);
        check("mb_level", 32'(bus_a.o_level), 32'd2);
        check("mb_head0", head_a(), ev(1'b0, 1'b0, 8'h1D));
        pop();
        check("mb_head1", head_a(), ev(1'b0, 1'b1, 8'h1D));
        pop();
        check("mb_empty", 32'(bus_a.o_level), 32'd0);
        pop();
        check("pop_empty", 32'(bus_a.o_level), 32'd0);

        // extended make/break and the Pause sequence
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        for (int i = 0; i < 8; i++) send(seq_e1[i]);
        check("ext_level", 32'(bus_a.o_level), 32'd3);
        check("ext_make", head_a(), ev(1'b1, 1'b0, 8'h75));
        pop();
        check("ext_break", head_a(), ev(1'b1, 1'b1, 8'h75));
        pop();
        check("pause", head_a(), ev(1'b1, 1'b0, 8'hE1));
        check("pause_noerr", 32'(bus_a.o_seq_err), 32'd0);
        drain();

        // typematic repeat filtering
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("rep_level_filt", 32'(bus_a.o_level), 32'd2);
        check("rep_level_nofilt", 32'(bus_b.o_level), 32'd4);
        check("rep_head0", head_a(), ev(1'b0, 1'b0, 8'h1C));
        pop();
        check("rep_head1", head_a(), ev(1'b0, 1'b1, 8'h1C));
        drain();

        // stray prefix restarts the sequence
        send(8'hF0);
        send(8'hE0);
        check("stray_seqerr", 32'(bus_a.o_seq_err), 32'd1);
        send(8'h75);
        check("stray_seqerr_clr", 32'(bus_a.o_seq_err), 32'd0);
        check("stray_evt", head_a(), ev(1'b1, 1'b0, 8'h75));
        drain();

        // control byte inside a prefix sequence is ignored
        send(8'hE0); send(8'hFA); send(8'h1F);
        check("ctrl_skip", head_a(), ev(1'b1, 1'b0, 8'h1F));
        check("ctrl_level", 32'(bus_a.o_level), 32'd1);
        drain();

        // inter-byte timeout
        send(8'hE0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 4 * int'(TMO)) begin
            tick();
            n++;
            seen = bus_a.o_seq_err;
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_window", 32'((n >= int'(TMO) - 1) && (n <= int'(TMO) + 1)), 32'd1);
        tick();
        check("tmo_pulse", 32'(bus_a.o_seq_err), 32'd0);
        check("tmo_noevt", 32'(bus_a.o_level), 32'd0);
        send(8'h23);
        check("tmo_next", head_a(), ev(1'b0, 1'b0, 8'h23));
        drain();

        // overflow, clear, and push+pop while full
        for (int i = 0; i < 9; i++) send(8'h30 + 8'(i));
        check("ovf_level", 32'(bus_a.o_level), 32'd8);
        check("ovf_set", 32'(bus_a.o_overflow), 32'd1);
        check("ovf_head", head_a(), ev(1'b0, 1'b0, 8'h30));
        bus_a.i_ovf_clr = 1'b1;
        tick();
        bus_a.i_ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus_a.o_overflow), 32'd0);
        bus_a.i_evt_ready = 1'b1;
        bus_b.i_evt_ready = 1'b1;
        send(8'h40);
        bus_a.i_evt_ready = 1'b0;
        bus_b.i_evt_ready = 1'b0;
        check("full_pp_level", 32'(bus_a.o_level), 32'd8);
        check("full_pp_head", head_a(), ev(1'b0, 1'b0, 8'h31));
        check("full_pp_ovf", 32'(bus_a.o_overflow), 32'd0);
        drain();

        // reset in the middle of a break sequence
        send(8'h50);
        send(8'hF0);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_head", head_a(), 32'h0);
        check("mid_rst_level", 32'(bus_a.o_level), 32'd0);
        tick();
        i_rst = 1'b0;
        tick();
        send(8'h1B);
        check("post_rst_make", head_a(), ev(1'b0, 1'b0, 8'h1B));
        check("post_rst_ovf", 32'(bus_a.o_overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
